// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS commit-trace capture buffer.
package mips_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rf_we;
        logic [4:0]  rf_wa;
        logic [31:0] rf_wd;
        logic        memwrite;
        logic [31:0] dataadr;
        logic [31:0] writedata;
    } trace_entry_t;

    typedef enum logic [1:0] {
        TRIG_PC     = 2'd0,
        TRIG_MEMADR = 2'd1,
        TRIG_MANUAL = 2'd2,
        TRIG_RSVD   = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array, one synchronous write port, one async read port.
module trace_ram
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [AW-1:0] i_waddr,
    input  trace_entry_t i_wdata,
    input  logic [AW-1:0] i_raddr,
    output trace_entry_t o_rdata
);

    trace_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: circular buffer with post-trigger stop and
// oldest-first valid/ready drain.
module commit_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int POST  = 8,
    parameter  int CNT_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic [1:0]       trig_mode,
    input  logic [31:0]      trig_val,
    input  logic             trig_now,
    input  logic             cap_valid,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             rf_we,
    input  logic [4:0]       rf_wa,
    input  logic [31:0]      rf_wd,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             busy,
    output logic             triggered,
    output logic             done,
    output logic [AW:0]      count,
    output logic [AW-1:0]    trig_index,
    output logic [CNT_W-1:0] trig_cycles,
    output logic             rd_valid,
    input  logic             rd_ready,
    output trace_entry_t     rd_data,
    output logic             rd_last
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_state_e r_state, w_state_nxt;
    logic [AW-1:0]    r_wr_ptr, r_trig_slot, r_post_cnt;
    logic [AW:0]      r_count, r_rd_idx;
    logic             r_triggered;
    logic [CNT_W-1:0] r_trig_cycles;

    trig_mode_e   w_mode;
    trace_entry_t w_entry, w_rd_entry;
    logic [AW-1:0] w_oldest, w_rd_addr;
    logic w_hit, w_arm_ok, w_capture, w_fire, w_beat;

    assign w_mode  = trig_mode_e'(trig_mode);
    assign w_entry = '{pc: pc, instr: instr, rf_we: rf_we, rf_wa: rf_wa,
                       rf_wd: rf_wd, memwrite: memwrite, dataadr: dataadr,
                       writedata: writedata};

    always_comb begin
        w_hit = 1'b0;
        unique case (w_mode)
            TRIG_PC:     w_hit = (pc == trig_val);
            TRIG_MEMADR: w_hit = memwrite && (dataadr == trig_val);
            TRIG_MANUAL: w_hit = trig_now;
            default:     w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arm_ok    = 1'b0;
        w_capture   = 1'b0;
        w_fire      = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        w_arm_ok    = 1'b1;
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    w_capture = cap_valid;
                    if (cap_valid && w_hit) begin
                        w_fire      = 1'b1;
                        w_state_nxt = (POST == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    w_capture = cap_valid;
                    if (cap_valid && r_post_cnt == AW'(1)) w_state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (arm) begin
                        w_arm_ok    = 1'b1;
                        w_state_nxt = ST_ARMED;
                    end else if (w_beat && rd_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_triggered   <= 1'b0;
            r_trig_cycles <= '0;
            r_trig_slot   <= '0;
            r_post_cnt    <= '0;
            r_rd_idx      <= '0;
        end else if (w_arm_ok) begin
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_triggered   <= 1'b0;
            r_trig_cycles <= '0;
            r_trig_slot   <= '0;
            r_post_cnt    <= '0;
            r_rd_idx      <= '0;
        end else begin
            if (r_state == ST_ARMED && !abort && r_trig_cycles != '1)
                r_trig_cycles <= r_trig_cycles + CNT_W'(1);
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_count != FULL) r_count <= r_count + (AW+1)'(1);
            end
            if (w_fire) begin
                r_triggered <= 1'b1;
                r_trig_slot <= r_wr_ptr;
                r_post_cnt  <= AW'(POST);
            end else if (w_capture && r_state == ST_POST) begin
                r_post_cnt <= r_post_cnt - AW'(1);
            end
            if (w_beat) r_rd_idx <= r_rd_idx + (AW+1)'(1);
        end
    end

    // Once the buffer has wrapped, the next write slot holds the oldest entry.
    assign w_oldest  = (r_count == FULL) ? r_wr_ptr : '0;
    assign w_rd_addr = w_oldest + r_rd_idx[AW-1:0];

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_capture),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_entry),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_entry)
    );

    assign busy        = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign done        = (r_state == ST_DONE);
    assign triggered   = r_triggered;
    assign count       = r_count;
    assign trig_cycles = r_trig_cycles;
    assign trig_index  = r_trig_slot - w_oldest;
    assign rd_valid    = done && (r_rd_idx < r_count);
    assign rd_last     = rd_valid && (r_rd_idx == r_count - (AW+1)'(1));
    assign rd_data     = rd_valid ? w_rd_entry : '0;
    assign w_beat      = rd_valid && rd_ready;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized and directed bench for commit_trace_buffer against a
// queue-based reference model.
`define W(v) (167'(v))
module tb_commit_trace_buffer;
    import mips_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int POST  = 3;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset, arm, abort, trig_now, cap_valid;
    logic [1:0] trig_mode;
    logic [31:0] trig_val, pc, instr, rf_wd, dataadr, writedata;
    logic rf_we, memwrite, rd_ready;
    logic [4:0] rf_wa;
    logic busy, triggered, done, rd_valid, rd_last;
    logic [3:0] count;
    logic [2:0] trig_index;
    logic [31:0] trig_cycles;
    trace_entry_t rd_data;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .POST(POST), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_val(trig_val), .trig_now(trig_now),
        .cap_valid(cap_valid), .pc(pc), .instr(instr), .rf_we(rf_we),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .busy(busy),
        .triggered(triggered), .done(done), .count(count),
        .trig_index(trig_index), .trig_cycles(trig_cycles),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last)
    );

    // Reference model: every entry captured since arm, in order.
    trace_entry_t mq[$];
    bit m_armed, m_post, m_done, m_trig;
    int m_trig_pos, m_post_left, m_beats;
    longint m_cycles;
    int n_assert = 0;
    int n_fail = 0;

    function automatic int held();
        return (mq.size() < DEPTH) ? mq.size() : DEPTH;
    endfunction

    function automatic int base();
        return mq.size() - held();
    endfunction

    function automatic bit m_rd_valid();
        return m_done && (m_beats < held());
    endfunction

    task automatic model_reset();
        mq.delete();
        m_armed = 0; m_post = 0; m_done = 0; m_trig = 0;
        m_trig_pos = 0; m_post_left = 0; m_beats = 0; m_cycles = 0;
    endtask

    task automatic model_step();
        trace_entry_t e;
        bit hit;
        e = {pc, instr, rf_we, rf_wa, rf_wd, memwrite, dataadr, writedata};
        case (trig_mode)
            2'd0:    hit = (pc == trig_val);
            2'd1:    hit = memwrite && (dataadr == trig_val);
            2'd2:    hit = trig_now;
            default: hit = 0;
        endcase
        if (abort) begin
            m_armed = 0; m_post = 0; m_done = 0;
        end else if (!m_armed && !m_post && arm) begin
            mq.delete();
            m_trig = 0; m_cycles = 0; m_beats = 0;
            m_armed = 1; m_done = 0;
        end else if (m_armed) begin
            if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
            if (cap_valid) begin
                mq.push_back(e);
                if (hit) begin
                    m_trig = 1;
                    m_trig_pos = mq.size() - 1;
                    m_armed = 0;
                    if (POST == 0) m_done = 1;
                    else begin m_post = 1; m_post_left = POST; end
                end
            end
        end else if (m_post) begin
            if (cap_valid) begin
                mq.push_back(e);
                m_post_left--;
                if (m_post_left == 0) begin m_post = 0; m_done = 1; end
            end
        end else if (m_rd_valid() && rd_ready) begin
            m_beats++;
            if (m_beats == held()) m_done = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [166:0] obs,
                       input logic [166:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit ev;
        ev = m_rd_valid();
        chk("busy", `W(busy), `W(m_armed || m_post));
        chk("done", `W(done), `W(m_done));
        chk("triggered", `W(triggered), `W(m_trig));
        chk("count", `W(count), `W(held()));
        chk("trig_cycles", `W(trig_cycles), `W(m_cycles));
        chk("rd_valid", `W(rd_valid), `W(ev));
        chk("rd_last", `W(rd_last), `W(ev && (m_beats == held() - 1)));
        if (ev) chk("rd_data", `W(rd_data), `W(mq[base() + m_beats]));
        if (m_trig) chk("trig_index", `W(trig_index), `W(m_trig_pos - base()));
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_busy"}, `W(busy), `W(0));
        chk({tag, "_done"}, `W(done), `W(0));
        chk({tag, "_trig"}, `W(triggered), `W(0));
        chk({tag, "_count"}, `W(count), `W(0));
        chk({tag, "_tidx"}, `W(trig_index), `W(0));
        chk({tag, "_tcyc"}, `W(trig_cycles), `W(0));
        chk({tag, "_rdv"}, `W(rd_valid), `W(0));
        chk({tag, "_rdd"}, `W(rd_data), `W(0));
        chk({tag, "_rdl"}, `W(rd_last), `W(0));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_payload();
        instr = $urandom; rf_we = 1'($urandom); rf_wa = 5'($urandom);
        rf_wd = $urandom; writedata = $urandom;
    endtask

    task automatic pulse_arm();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic feed_pcs(input logic [31:0] start);
        memwrite = 0; dataadr = 0;
        for (int i = 0; i < 40 && !m_done; i++) begin
            cap_valid = 1; pc = start + 32'(4 * i); rand_payload();
            tick();
        end
        cap_valid = 0;
        chk("reach_done", `W(done), `W(1));
    endtask

    task automatic drain();
        rd_ready = 1;
        for (int i = 0; i < 40 && m_done; i++) tick();
        rd_ready = 0;
        chk("drain_idle", `W(done), `W(0));
    endtask

    initial begin
        int nb;
        reset = 0; arm = 0; abort = 0; trig_mode = 0; trig_val = 0;
        trig_now = 0; cap_valid = 0; pc = 0; instr = 0; rf_we = 0;
        rf_wa = 0; rf_wd = 0; memwrite = 0; dataadr = 0; writedata = 0;
        rd_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        zero_checks("reset");
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            cap_valid = 1; pc = $urandom; rand_payload(); tick();
        end
        cap_valid = 0;

        // Wrapped capture, PC trigger at 0x14
        trig_mode = 0; trig_val = 32'h14;
        pulse_arm();
        feed_pcs(0);
        chk("t1_count", `W(count), `W(8));
        chk("t1_tidx", `W(trig_index), `W(4));
        chk("t1_first", `W(rd_data.pc), `W(32'h4));
        drain();

        // Under-filled capture
        trig_val = 0;
        pulse_arm();
        feed_pcs(0);
        chk("uf_count", `W(count), `W(4));
        chk("uf_tidx", `W(trig_index), `W(0));
        chk("uf_tcyc", `W(trig_cycles), `W(1));
        drain();

        // Memwrite-address trigger
        trig_mode = 1; trig_val = 32'h54;
        pulse_arm();
        cap_valid = 1; pc = 32'h100; rand_payload();
        memwrite = 0; dataadr = 32'h54; tick();
        chk("m1_notrig", `W(triggered), `W(0));
        pc = 32'h104; memwrite = 1; writedata = 7; tick();
        chk("m1_trig", `W(triggered), `W(1));
        feed_pcs(32'h200);
        chk("m1_tidx", `W(trig_index), `W(1));
        rd_ready = 1; tick(); rd_ready = 0;
        chk("m1_wd", `W(rd_data.writedata), `W(7));
        drain();

        // Backpressure
        trig_mode = 0; trig_val = 32'h14;
        pulse_arm();
        feed_pcs(0);
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            rd_ready = (i % 2 == 0);
            if (rd_valid && rd_ready) nb++;
            tick();
        end
        rd_ready = 0;
        chk("bp_beats", `W(nb), `W(8));
        chk("bp_idle", `W(done), `W(0));

        // Abort in POST; arm with abort
        trig_mode = 2;
        pulse_arm();
        cap_valid = 1; trig_now = 1; pc = 32'h40; tick();
        trig_now = 0; pc = 32'h44; tick();
        chk("ab_post", `W(busy), `W(1));
        cap_valid = 0; abort = 1; tick(); abort = 0;
        chk("ab_busy", `W(busy), `W(0));
        chk("ab_done", `W(done), `W(0));
        arm = 1; abort = 1; tick(); arm = 0; abort = 0;
        chk("armab_busy", `W(busy), `W(0));

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            arm = ($urandom_range(0, 99) < 6);
            abort = ($urandom_range(0, 99) < 2);
            if (arm) begin
                trig_mode = 2'($urandom);
                trig_val = 32'(4 * $urandom_range(0, 15));
            end
            cap_valid = ($urandom_range(0, 99) < 60);
            trig_now = ($urandom_range(0, 99) < 15);
            pc = 32'(4 * $urandom_range(0, 15));
            memwrite = ($urandom_range(0, 99) < 30);
            dataadr = 32'(4 * $urandom_range(0, 15));
            rd_ready = 1'($urandom);
            rand_payload();
            tick();
        end
        arm = 0; abort = 1; cap_valid = 0; tick(); abort = 0;

        // Reset during readout
        trig_mode = 0; trig_val = 32'h14;
        pulse_arm();
        feed_pcs(0);
        rd_ready = 1; tick(); rd_ready = 0;
        reset = 0;
        #1;
        model_reset();
        zero_checks("midrst");
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            cap_valid = 1; pc = 32'h14; rand_payload(); tick();
        end
        cap_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
`undef W

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

On-chip commit-trace capture for the single-cycle MIPS core: records one entry per committed instruction (pc, instr, register-file write, data-memory write) into a circular buffer. Capture stops a programmable number of entries after a trigger; the buffer is then drained oldest-first over a valid/ready stream. Sits beside `top`, tapping the same signals the bench prints, so silicon and FPGA runs yield the same per-cycle record as simulation.

## Interface
- `DEPTH`, 16: entries stored; power of 2, ≥ 4.
- `POST`, 8: entries captured after (excluding) the trigger entry; 0 ≤ POST < DEPTH.
- `CNT_W`, 32: width of trigger-cycle counter.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `arm`  in  1  pulse: start capture (accepted in IDLE/DONE only).
- `abort`  in  1  pulse: return to IDLE from any state; wins over `arm`.
- `trig_mode`  in  2  0 = PC match, 1 = memwrite-address match, 2 = manual, 3 = reserved (never triggers).
- `trig_val`  in  32  compare value for modes 0/1.
- `trig_now`  in  1  manual trigger (mode 2).
- `cap_valid`  in  1  an instruction commits this cycle.
- `pc`, `instr`  in  32 each  committed pc / instruction.
- `rf_we`  in  1; `rf_wa`  in  5; `rf_wd`  in  32  register-file write.
- `memwrite`  in  1; `dataadr`  in  32; `writedata`  in  32  data-memory write.
- `busy`  out  1  state is ARMED or POST.
- `triggered`  out  1  trigger seen since last arm.
- `done`  out  1  state is DONE.
- `count`  out  $clog2(DEPTH)+1  valid entries held.
- `trig_index`  out  $clog2(DEPTH)  readout position of trigger entry.
- `trig_cycles`  out  CNT_W  clk cycles from arm to trigger, saturating.
- `rd_valid`  out  1; `rd_ready`  in  1; `rd_data`  out  167  {pc, instr, rf_we, rf_wa, rf_wd, memwrite, dataadr, writedata}; `rd_last`  out  1.

## Operation
- States: IDLE, ARMED, POST, DONE. Reset: IDLE, all outputs 0, pointers/counters 0.
- IDLE/DONE + `arm` (no `abort`) → ARMED; clears wr_ptr, count, triggered, trig_cycles, readout.
- ARMED: each `cap_valid` writes entry at wr_ptr, wr_ptr++ mod DEPTH, count saturates at DEPTH; trig_cycles increments every cycle.
- Trigger (ARMED, `cap_valid` high): mode 0 `pc==trig_val`; mode 1 `memwrite && dataadr==trig_val`; mode 2 `trig_now`. Trigger entry is itself stored; post_cnt ← POST; → POST, or DONE if POST=0.
- POST: each `cap_valid` writes, post_cnt--; entry making post_cnt 0 → DONE. Further triggers ignored.
- IDLE/DONE: `cap_valid` ignored. `arm` in ARMED/POST ignored.
- Readout (DONE): oldest = 0 if count<DEPTH else wr_ptr; `rd_valid` while entries remain; beat transfers on `rd_valid && rd_ready`; `rd_last` on final beat; after final beat → IDLE (count retained until next arm).
- trig_index = (trigger slot − oldest) mod DEPTH; equals count−1−POST.
- `abort` anywhere → IDLE, readout cancelled, busy/done 0.

## Timing
- Capture and state changes take effect on the rising `clk` edge where inputs are sampled; trigger compare is combinational on current inputs.
- `done` and `rd_valid` rise the cycle after the edge that stores the final entry.
- `rd_data`/`rd_last` are a function of registered rd_ptr only; held stable while `rd_valid && !rd_ready`.
- Full throughput: one beat per cycle with `rd_ready` held high.
- `reset` low mid-operation: immediate return to reset values, no partial readout.

## Structure
- Package `mips_trace_pkg`: `trace_entry_t` packed struct (167 bits), `trig_mode_e`, `trace_state_e`.
- Sub-module `trace_ram`: DEPTH × 167 register array, one sync write port, one async read port.

## Test plan
(DEPTH=8, POST=3.)
- Reset low: all outputs 0, `rd_valid` 0; release, no `arm` → stays IDLE under cap_valid.
- Mode 0, trig_val=0x14, pcs 0x00,0x04,… each cycle: 9 captured, readout 8 beats pc 0x04..0x20, trig_index=4, `rd_last` on 0x20, then IDLE.
- Under-fill: trigger on first pc 0x00 → count=4, beats 0x00..0x0C, trig_index=0, trig_cycles=1 when cap_valid lands the cycle after arm.
- Mode 1, trig_val=0x54: entry memwrite=0 dataadr=0x54 does not trigger; next entry memwrite=1 dataadr=0x54 writedata=7 does; that beat shows writedata=7.
- Backpressure: `rd_ready` toggling 1/0 → 8 beats over 16 cycles, `rd_data` unchanged across stall cycles, no beat lost or repeated.
- `abort` in POST → IDLE, done 0; `arm`+`abort` same cycle → IDLE; `reset` low during readout → all outputs 0.
